// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decode_stage                                                  |
// | Purpose  : Pipeline instruction-decode stage. Accepts an instruction and |
// |            PC from fetch, classifies the opcode, fetches source operands |
// |            over two request/acknowledge register-file read ports (acks   |
// |            in any order) and presents IR/PC/X/Y to execute. Supports     |
// |            stall, flush, illegal-opcode flagging and sticky HALT.        |
// | Ports    : clk, rst_n (async, active low)                                |
// |            in_ir/in_pc/in_valid/in_ready       - fetch handshake         |
// |            out_ir/out_pc/out_x/out_y/out_illegal/out_valid/out_ready     |
// |                                                - execute handshake       |
// |            rdN_addr/rdN_en/rdN_ack/rdN_data    - register-file reads     |
// |            stall, flush                        - pipeline control        |
// |            halted                              - sticky HALT retired     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module decode_stage #(
  parameter int unsigned WIDTH        = 32,   // >= 32
  parameter int unsigned REG_ADDR_LEN = 5,    // <= 5
  parameter logic [5:0]  OP_RTYPE     = 6'h00,
  parameter logic [5:0]  OP_ITYPE     = 6'h01,
  parameter logic [5:0]  OP_BRANCH    = 6'h02,
  parameter logic [5:0]  OP_JTYPE     = 6'h03,
  parameter logic [5:0]  OP_NOP       = 6'h3E,
  parameter logic [5:0]  OP_HALT      = 6'h3F
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_ir,
  input  logic [WIDTH-3:0]        in_pc,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_ir,
  output logic [WIDTH-3:0]        out_pc,
  output logic [WIDTH-1:0]        out_x,
  output logic [WIDTH-1:0]        out_y,
  output logic                    out_illegal,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REG_ADDR_LEN-1:0] rd1_addr,
  output logic [REG_ADDR_LEN-1:0] rd2_addr,
  output logic                    rd1_en,
  output logic                    rd2_en,
  input  logic                    rd1_ack,
  input  logic                    rd2_ack,
  input  logic [WIDTH-1:0]        rd1_data,
  input  logic [WIDTH-1:0]        rd2_data,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    halted
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_VALID = 2'd2;

  localparam logic [WIDTH-1:0] c_NOP_WORD = WIDTH'({OP_NOP, 26'b0});

  // FSM
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  // Datapath registers
  logic [WIDTH-1:0]        r_ir;
  logic [WIDTH-3:0]        r_pc;
  logic [WIDTH-1:0]        r_x;
  logic [WIDTH-1:0]        r_y;
  logic                    r_illegal;
  logic                    r_is_halt;
  logic                    r_halted;
  logic [REG_ADDR_LEN-1:0] r_rd1_addr;
  logic [REG_ADDR_LEN-1:0] r_rd2_addr;
  logic                    r_rd1_en;
  logic                    r_rd2_en;

  // Decode of the incoming word
  logic [5:0]              w_opcode;
  logic [REG_ADDR_LEN-1:0] w_rd;
  logic [REG_ADDR_LEN-1:0] w_rs;
  logic [REG_ADDR_LEN-1:0] w_rt;
  logic [WIDTH-1:0]        w_simm;
  logic [WIDTH-1:0]        w_tgt;
  logic                    w_need1;
  logic                    w_need2;
  logic [REG_ADDR_LEN-1:0] w_a1;
  logic [REG_ADDR_LEN-1:0] w_a2;
  logic [WIDTH-1:0]        w_x;
  logic [WIDTH-1:0]        w_y;
  logic                    w_illegal;
  logic                    w_is_halt;

  // Control strobes
  logic w_accept;
  logic w_out_hs;
  logic w_take1;
  logic w_take2;
  logic w_en1_nxt;
  logic w_en2_nxt;

  assign w_opcode = in_ir[31:26];
  assign w_rd     = in_ir[21 +: REG_ADDR_LEN];
  assign w_rs     = in_ir[16 +: REG_ADDR_LEN];
  assign w_rt     = in_ir[11 +: REG_ADDR_LEN];
  assign w_simm   = WIDTH'($signed(in_ir[15:0]));
  assign w_tgt    = WIDTH'(in_ir[25:0]);

  // Opcode classification. An if-chain rather than a case keeps the
  // behaviour well defined even if two opcode parameters are set equal.
  always_comb begin
    w_need1   = 1'b0;
    w_need2   = 1'b0;
    w_a1      = '0;
    w_a2      = '0;
    w_x       = '0;
    w_y       = '0;
    w_illegal = 1'b0;
    w_is_halt = 1'b0;
    if (w_opcode == OP_RTYPE) begin
      w_need1 = 1'b1;
      w_need2 = 1'b1;
      w_a1    = w_rs;
      w_a2    = w_rt;
    end else if (w_opcode == OP_ITYPE) begin
      w_need1 = 1'b1;
      w_a1    = w_rs;
      w_y     = w_simm;
    end else if (w_opcode == OP_BRANCH) begin
      w_need1 = 1'b1;
      w_a1    = w_rd;
      w_y     = w_simm;
    end else if (w_opcode == OP_JTYPE) begin
      w_x     = w_tgt;
    end else if (w_opcode == OP_NOP) begin
      // no reads, zero operands
    end else if (w_opcode == OP_HALT) begin
      w_is_halt = 1'b1;
    end else begin
      w_illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- FSM: outputs / strobes
  always_comb begin
    in_ready  = 1'b0;
    out_valid = (r_state == c_ST_VALID);
    // A held HALT blocks the back-to-back accept so nothing follows it in.
    if (!stall && !r_halted) begin
      if (r_state == c_ST_IDLE) begin
        in_ready = 1'b1;
      end else if (r_state == c_ST_VALID) begin
        in_ready = out_ready && !r_is_halt;
      end
    end
    // in_ready is not masked by flush; a flush simply discards the accept.
    w_accept  = in_valid && in_ready && !flush;
    w_out_hs  = (r_state == c_ST_VALID) && out_ready && !stall && !flush;
    w_take1   = (r_state == c_ST_READ) && r_rd1_en && rd1_ack && !stall && !flush;
    w_take2   = (r_state == c_ST_READ) && r_rd2_en && rd2_ack && !stall && !flush;
    w_en1_nxt = r_rd1_en && !w_take1;
    w_en2_nxt = r_rd2_en && !w_take2;
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_ST_IDLE;
    end else if (!stall) begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = (w_need1 || w_need2) ? c_ST_READ : c_ST_VALID;
          end
        end
        c_ST_READ: begin
          if (!w_en1_nxt && !w_en2_nxt) begin
            w_state_nxt = c_ST_VALID;
          end
        end
        c_ST_VALID: begin
          if (w_out_hs) begin
            if (w_accept) begin
              w_state_nxt = (w_need1 || w_need2) ? c_ST_READ : c_ST_VALID;
            end else begin
              w_state_nxt = c_ST_IDLE;
            end
          end
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= c_NOP_WORD;
      r_pc       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_illegal  <= 1'b0;
      r_is_halt  <= 1'b0;
      r_halted   <= 1'b0;
      r_rd1_addr <= '0;
      r_rd2_addr <= '0;
      r_rd1_en   <= 1'b0;
      r_rd2_en   <= 1'b0;
    end else if (flush) begin
      // halted is deliberately left untouched: only reset clears it.
      r_ir     <= c_NOP_WORD;
      r_rd1_en <= 1'b0;
      r_rd2_en <= 1'b0;
    end else if (!stall) begin
      if (w_accept) begin
        r_ir       <= in_ir;
        r_pc       <= in_pc;
        r_x        <= w_x;
        r_y        <= w_y;
        r_illegal  <= w_illegal;
        r_is_halt  <= w_is_halt;
        r_rd1_addr <= w_a1;
        r_rd2_addr <= w_a2;
        r_rd1_en   <= w_need1;
        r_rd2_en   <= w_need2;
      end else begin
        // Accept and ack capture are mutually exclusive (IDLE/VALID vs READ).
        if (w_take1) begin
          r_x      <= rd1_data;
          r_rd1_en <= 1'b0;
        end
        if (w_take2) begin
          r_y      <= rd2_data;
          r_rd2_en <= 1'b0;
        end
      end
      if (w_out_hs && r_is_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign out_ir      = r_ir;
  assign out_pc      = r_pc;
  assign out_x       = r_x;
  assign out_y       = r_y;
  assign out_illegal = r_illegal;
  assign rd1_addr    = r_rd1_addr;
  assign rd2_addr    = r_rd2_addr;
  assign rd1_en      = r_rd1_en;
  assign rd2_en      = r_rd2_en;
  assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_decode_stage                                               |
// | Purpose  : Self-checking bench for decode_stage: directed scenarios with |
// |            literal expectations, then randomized traffic checked every   |
// |            cycle against a transaction-level model of the stage.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_decode_stage;

  localparam logic [31:0] NOP_WORD = 32'hF800_0000;
  localparam logic [31:0] R_WORD   = 32'h0002_1800;
  localparam logic [31:0] I_WORD   = 32'h0404_FFFE;
  localparam logic [31:0] J_WORD   = 32'h0FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_ir;
  logic [29:0] in_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_ir;
  logic [29:0] out_pc;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic        out_illegal;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rd1_addr;
  logic [4:0]  rd2_addr;
  logic        rd1_en;
  logic        rd2_en;
  logic        rd1_ack;
  logic        rd2_ack;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic        stall;
  logic        flush;
  logic        halted;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_ir(in_ir), .in_pc(in_pc), .in_valid(in_valid), .in_ready(in_ready),
    .out_ir(out_ir), .out_pc(out_pc), .out_x(out_x), .out_y(out_y),
    .out_illegal(out_illegal), .out_valid(out_valid), .out_ready(out_ready),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_en(rd1_en), .rd2_en(rd2_en),
    .rd1_ack(rd1_ack), .rd2_ack(rd2_ack), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .stall(stall), .flush(flush), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct packed {
    bit          r1;
    bit          r2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] x;
    logic [31:0] y;
    bit          ill;
    bit          halt;
  } dec_t;

  // Stage contents as a transaction: is something held, which reads are
  // still outstanding, and the fields that will be presented.
  bit          m_hold, m_p1, m_p2, m_is_halt, m_halted, m_ill;
  logic [31:0] m_ir, m_x, m_y;
  logic [29:0] m_pc;
  logic [4:0]  m_a1, m_a2;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    logic [31:0] imm, sext;
    d = '0;
    imm  = w % 32'h1_0000;
    sext = (imm >= 32'h8000) ? imm + 32'hFFFF_0000 : imm;
    case (w[31:26])
      6'h00: begin d.r1 = 1; d.r2 = 1; d.a1 = w[20:16]; d.a2 = w[15:11]; end
      6'h01: begin d.r1 = 1; d.a1 = w[20:16]; d.y = sext; end
      6'h02: begin d.r1 = 1; d.a1 = w[25:21]; d.y = sext; end
      6'h03: d.x = w % 32'h0400_0000;
      6'h3E: ;
      6'h3F: d.halt = 1;
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic bit exp_valid();
    return m_hold && !m_p1 && !m_p2;
  endfunction

  function automatic bit exp_in_ready();
    return !stall && !m_halted && (!m_hold || (exp_valid() && out_ready && !m_is_halt));
  endfunction

  task automatic model_reset();
    m_hold = 0; m_p1 = 0; m_p2 = 0; m_is_halt = 0; m_halted = 0; m_ill = 0;
    m_ir = NOP_WORD; m_x = '0; m_y = '0; m_pc = '0; m_a1 = '0; m_a2 = '0;
  endtask

  task automatic model_step();
    bit hs, acc;
    dec_t d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (flush) begin
      m_hold = 0; m_p1 = 0; m_p2 = 0; m_ir = NOP_WORD;
      return;
    end
    if (stall) return;
    hs  = exp_valid() && out_ready;
    acc = in_valid && exp_in_ready();
    if (hs) begin
      if (m_is_halt) m_halted = 1;
      m_hold = 0;
    end
    if (m_p1 && rd1_ack) begin m_x = rd1_data; m_p1 = 0; end
    if (m_p2 && rd2_ack) begin m_y = rd2_data; m_p2 = 0; end
    if (acc) begin
      d = decode(in_ir);
      m_hold = 1; m_ir = in_ir; m_pc = in_pc;
      m_p1 = d.r1; m_p2 = d.r2; m_a1 = d.a1; m_a2 = d.a2;
      m_x = d.x; m_y = d.y; m_ill = d.ill; m_is_halt = d.halt;
    end
  endtask

  // ---------------------------------------------------------------- compare process
  always @(negedge clk) begin
    #1;
    chk("in_ready",  64'(in_ready),  64'(exp_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(exp_valid()));
    chk("rd1_en",    64'(rd1_en),    64'(m_p1));
    chk("rd2_en",    64'(rd2_en),    64'(m_p2));
    chk("halted",    64'(halted),    64'(m_halted));
    chk("out_ir",    64'(out_ir),    64'(m_ir));
    chk("out_pc",    64'(out_pc),    64'(m_pc));
    chk("out_illegal", 64'(out_illegal), 64'(m_ill));
    if (m_p1) chk("rd1_addr", 64'(rd1_addr), 64'(m_a1));
    if (m_p2) chk("rd2_addr", 64'(rd2_addr), 64'(m_a2));
    if (exp_valid()) begin
      chk("out_x", 64'(out_x), 64'(m_x));
      chk("out_y", 64'(out_y), 64'(m_y));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; rd1_ack = 0; rd2_ack = 0; stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  op;
    int unsigned k;
    w = $urandom;
    k = $urandom % 16;
    case (k)
      0, 1, 2, 3: op = 6'h00;
      4, 5, 6:    op = 6'h01;
      7, 8:       op = 6'h02;
      9, 10:      op = 6'h03;
      11:         op = 6'h3E;
      12:         op = ($urandom % 8 == 0) ? 6'h3F : 6'h03;
      default:    op = 6'($urandom);
    endcase
    w[31:26] = op;
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; idle_inputs();
    in_ir = '0; in_pc = '0; rd1_data = '0; rd2_data = '0;
    model_reset();
    tick(); tick();
    rst_n = 1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_ir",   64'(out_ir),   64'(NOP_WORD));
    chk("rst_out_valid", 64'(out_valid), 64'(0));

    // R-type, acks out of order
    in_valid = 1; in_ir = R_WORD; in_pc = 30'h100;
    tick();
    in_valid = 0; rd2_ack = 1; rd2_data = 32'h22;
    #2;
    chk("t1_rd1_en", 64'(rd1_en), 64'(1));
    chk("t1_rd2_en", 64'(rd2_en), 64'(1));
    chk("t1_rd1_addr", 64'(rd1_addr), 64'(2));
    chk("t1_rd2_addr", 64'(rd2_addr), 64'(3));
    tick();
    rd2_ack = 0;
    #2;
    chk("t1_rd2_dropped", 64'(rd2_en), 64'(0));
    chk("t1_rd1_held", 64'(rd1_en), 64'(1));
    tick();
    rd1_ack = 1; rd1_data = 32'h11;
    #2 chk("t1_not_valid", 64'(out_valid), 64'(0));
    tick();
    rd1_ack = 0; out_ready = 1;
    #2;
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_x", 64'(out_x), 64'(32'h11));
    chk("t1_y", 64'(out_y), 64'(32'h22));
    chk("t1_model_x", 64'(m_x), 64'(32'h11));
    tick();
    out_ready = 0;

    // I-type with a spurious ack on the unrequested port
    in_valid = 1; in_ir = I_WORD; in_pc = 30'h104;
    tick();
    in_valid = 0; rd2_ack = 1; rd2_data = 32'hDEAD;
    #2;
    chk("t2_rd1_en", 64'(rd1_en), 64'(1));
    chk("t2_rd2_en", 64'(rd2_en), 64'(0));
    chk("t2_rd1_addr", 64'(rd1_addr), 64'(4));
    tick();
    rd2_ack = 0; rd1_ack = 1; rd1_data = 32'h5;
    tick();
    rd1_ack = 0; out_ready = 1;
    #2;
    chk("t2_valid", 64'(out_valid), 64'(1));
    chk("t2_x", 64'(out_x), 64'(32'h5));
    chk("t2_y", 64'(out_y), 64'(32'hFFFF_FFFE));
    chk("t2_model_y", 64'(m_y), 64'(32'hFFFF_FFFE));
    tick();

    // J-type back-to-back, then backpressure
    in_valid = 1; in_ir = J_WORD; in_pc = 30'h200;
    tick();
    for (int i = 1; i <= 2; i++) begin
      in_pc = 30'h200 + 30'(i);
      #2;
      chk("t3_valid", 64'(out_valid), 64'(1));
      chk("t3_pc", 64'(out_pc), 64'(30'h200 + 30'(i - 1)));
      chk("t3_x", 64'(out_x), 64'(32'h03FF_FFFF));
      chk("t3_y", 64'(out_y), 64'(0));
      tick();
    end
    in_pc = 30'h203; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t3_hold_valid", 64'(out_valid), 64'(1));
      chk("t3_hold_in_ready", 64'(in_ready), 64'(0));
      chk("t3_hold_pc", 64'(out_pc), 64'(30'h202));
      tick();
    end
    out_ready = 1;
    #2 chk("t3_release_in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 0;
    #2 chk("t3_last_pc", 64'(out_pc), 64'(30'h203));
    tick();
    out_ready = 0;

    // stall and flush together while in READ
    in_valid = 1; in_ir = R_WORD; in_pc = 30'h300;
    tick();
    in_valid = 0; stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0; rd1_ack = 1; rd2_ack = 1;
    #2;
    chk("t4_rd1_en", 64'(rd1_en), 64'(0));
    chk("t4_rd2_en", 64'(rd2_en), 64'(0));
    chk("t4_out_ir", 64'(out_ir), 64'(32'hF800_0000));
    chk("t4_in_ready", 64'(in_ready), 64'(1));
    tick();
    rd1_ack = 0; rd2_ack = 0;
    #2 chk("t4_still_idle", 64'(out_valid), 64'(0));
    tick();

    // illegal opcode, then HALT
    in_valid = 1; in_ir = 32'h8000_0000; in_pc = 30'h400;
    tick();
    in_valid = 0; out_ready = 1;
    #2;
    chk("t5_valid", 64'(out_valid), 64'(1));
    chk("t5_illegal", 64'(out_illegal), 64'(1));
    chk("t5_x", 64'(out_x), 64'(0));
    chk("t5_y", 64'(out_y), 64'(0));
    chk("t5_no_read", 64'({rd1_en, rd2_en}), 64'(0));
    tick();
    in_valid = 1; in_ir = 32'hFC00_0000; out_ready = 0;
    tick();
    in_valid = 0; out_ready = 1;
    #2 chk("t5_halt_pending", 64'(halted), 64'(0));
    tick();
    in_valid = 1; in_ir = J_WORD;
    #2;
    chk("t5_halted", 64'(halted), 64'(1));
    chk("t5_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush = 1;
    tick();
    flush = 0;
    #2;
    chk("t5_flush_keeps_halted", 64'(halted), 64'(1));
    chk("t5_flush_in_ready", 64'(in_ready), 64'(0));
    tick();
    in_valid = 0; out_ready = 0;

    // asynchronous reset while in READ
    rst_n = 0; model_reset(); tick(); rst_n = 1; tick();
    in_valid = 1; in_ir = R_WORD; in_pc = 30'h500;
    tick();
    in_valid = 0;
    #2 chk("t6_pre_rd1_en", 64'(rd1_en), 64'(1));
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("t6_rst_rd1_en", 64'(rd1_en), 64'(0));
    chk("t6_rst_out_ir", 64'(out_ir), 64'(NOP_WORD));
    chk("t6_rst_out_pc", 64'(out_pc), 64'(0));
    chk("t6_rst_halted", 64'(halted), 64'(0));
    tick();
    rst_n = 1;
    in_valid = 1; in_ir = R_WORD; in_pc = 30'h504;
    tick();
    in_valid = 0; rd1_ack = 1; rd2_ack = 1; rd1_data = 32'hAA; rd2_data = 32'hBB;
    tick();
    rd1_ack = 0; rd2_ack = 0; out_ready = 1;
    #2;
    chk("t6_valid", 64'(out_valid), 64'(1));
    chk("t6_x", 64'(out_x), 64'(32'hAA));
    chk("t6_y", 64'(out_y), 64'(32'hBB));
    tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (m_halted && ($urandom % 6 == 0)) begin
        rst_n = 0;
        model_reset();
      end else begin
        rst_n = 1;
      end
      in_valid  = ($urandom % 3) != 0;
      in_ir     = rand_instr();
      in_pc     = 30'($urandom);
      out_ready = ($urandom % 4) != 0;
      stall     = ($urandom % 12) == 0;
      flush     = ($urandom % 25) == 0;
      rd1_ack   = ($urandom % 3) == 0;
      rd2_ack   = ($urandom % 3) == 0;
      rd1_data  = $urandom;
      rd2_data  = $urandom;
      tick();
    end
    rst_n = 1;
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Parametrised successor of the pipeline instruction-decode stage. Accepts one instruction word and its PC from fetch under a valid/ready handshake and decodes the opcode class. It then fetches source operands from the register file over request/acknowledge read ports, collecting acknowledges in any order. It presents the instruction, PC and X/Y operands to execute under a second valid/ready handshake, with stall, flush, illegal-opcode flagging and sticky HALT detection.

## Interface
Parameters:
- WIDTH, 32: datapath width; must be >= 32.
- REG_ADDR_LEN, 5: register address width; must be <= 5.
- OP_RTYPE, 6'h00: R-type opcode.
- OP_ITYPE, 6'h01: I-type opcode.
- OP_BRANCH, 6'h02: branch opcode.
- OP_JTYPE, 6'h03: J-type opcode.
- OP_NOP, 6'h3E: NOP opcode.
- OP_HALT, 6'h3F: HALT opcode.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_ir  in  WIDTH  instruction from fetch.
- in_pc  in  WIDTH-2  PC from fetch.
- in_valid  in  1  fetch offers in_ir/in_pc.
- in_ready  out  1  stage accepts this cycle.
- out_ir  out  WIDTH  decoded instruction.
- out_pc  out  WIDTH-2  its PC.
- out_x, out_y  out  WIDTH  operands.
- out_illegal  out  1  opcode matched no parameter.
- out_valid  out  1  outputs valid.
- out_ready  in  1  execute accepts.
- rd1_addr, rd2_addr  out  REG_ADDR_LEN  read addresses.
- rd1_en, rd2_en  out  1  read request, level, held until ack.
- rd1_ack, rd2_ack  in  1  single-cycle ack; data valid same cycle.
- rd1_data, rd2_data  in  WIDTH  read data.
- stall  in  1  freeze stage.
- flush  in  1  discard stage contents.
- halted  out  1  sticky; HALT has left the stage.

## Operation
- Fields: opcode [31:26], Rd [25:21], Rs [20:16], Rt [15:11], Imm [15:0], Tgt [25:0]. Register address is the low REG_ADDR_LEN bits of the field.
- Opcode classes:
  - R-type: rd1=Rs, rd2=Rt; X=rd1_data, Y=rd2_data.
  - I-type: rd1=Rs; X=rd1_data, Y=sign-extended Imm.
  - Branch: rd1=Rd; X=rd1_data, Y=sign-extended Imm.
  - J-type: no reads; X=zero-extended Tgt, Y=0.
  - NOP/HALT: no reads; X=Y=0.
  - Any other opcode: as NOP; out_illegal=1; out_ir keeps the original word.
- FSM states: IDLE, READ, VALID.
  - IDLE: in_ready=1. Accept (in_valid&in_ready) latches IR/PC and decode. If reads are needed, go to READ with the required rdN_en=1 from the next cycle; otherwise go to VALID.
  - READ: on each rdN_ack while rdN_en=1, capture data and drop rdN_en on the next cycle. Acks may arrive in either order or together. An ack on a port not requested is ignored. When all required acks are collected, go to VALID.
  - VALID: out_valid=1; outputs stable until out_ready. in_ready=out_ready, so a handshake plus a simultaneous accept loads the next instruction back-to-back. A handshake without in_valid returns to IDLE.
- Priority: reset > flush > stall > normal.
- flush: next state IDLE; rdN_en=0, out_valid=0, out_ir=NOP word ({OP_NOP,26'b0}); an in-flight accept is discarded. Acks arriving in IDLE are ignored.
- stall: no state, register or output change; in_ready=0; out handshake not taken.
- HALT: on its out handshake halted=1. After that, in_ready=0 permanently. flush does not clear halted; only rst_n does.

## Timing
- Reset values: state IDLE, in_ready=1 after release, out_valid=0, out_ir=NOP word, out_pc=0, out_x=0, out_y=0, out_illegal=0, rdN_addr=0, rdN_en=0, halted=0.
- No-read instruction: accepted at cycle N, out_valid at N+1. Throughput 1/cycle with out_ready=1.
- Read instruction: rdN_en at N+1. Earliest ack at N+1 gives out_valid at N+2. Latency is the last ack cycle +1.
- rst_n low mid-operation: all outputs go to reset values immediately (asynchronous).

## Test plan
- R-type 0x0002_1800: rd1_addr=2, rd2_addr=3, both en at N+1. rd2_ack data 0x22 at N+1, rd1_ack data 0x11 at N+3 -> rd2_en low at N+2, out_valid at N+4 with X=0x11, Y=0x22.
- I-type 0x0404_FFFE: only rd1_en (addr 4). Ack data 0x5 -> X=0x5, Y=0xFFFF_FFFE; a spurious rd2_ack is ignored.
- J-type 0x0FFF_FFFF x3 back-to-back, out_ready=1 -> out_valid at N+1..N+3, X=0x03FF_FFFF, Y=0. Repeat with out_ready=0 for 4 cycles -> outputs stable, in_ready=0.
- R-type in READ, stall=1 and flush=1 same cycle -> next cycle IDLE, rdN_en=0, out_ir=0xF800_0000. Later ack ignored, out_valid stays 0.
- Opcode 6'h20 -> out_illegal=1, X=Y=0, no reads. HALT 0xFC00_0000 handshaken -> halted=1, in_ready=0 thereafter, flush leaves halted=1.
- rst_n pulsed low while in READ -> outputs at reset values without a clock edge; after release, fresh R-type decodes normally.
